// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    localparam int DIV_WIDTH = 32;

    // Divide-by-zero quotient: the low w bits set (valid for w <= 64).
    function automatic logic [63:0] dbz_quotient(input int unsigned w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial subtract, select.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] p_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] p_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    assign shifted = {p_in, bit_in};
    assign trial   = shifted - {1'b0, divisor};

    // A clear sign bit means the divisor fit, so keep the difference.
    assign q_bit = ~trial[WIDTH];
    assign p_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle restoring divider with a start/busy/done handshake.
// Define SIGNED_DIV_EN to add the is_signed port for two's-complement operands.
module iterative_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef SIGNED_DIV_EN
    input  logic             is_signed,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [63:0]      DBZ_FULL = dbz_quotient(WIDTH);
    localparam logic [WIDTH-1:0] DBZ_Q    = DBZ_FULL[WIDTH-1:0];
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] p_q, q_q, dvs_q;
    logic [WIDTH-1:0] p_next, q_raw, q_res, r_res;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic             q_bit, accept, last;

    div_step #(.WIDTH(WIDTH)) u_step (
        .p_in    (p_q),
        .bit_in  (q_q[WIDTH-1]),
        .divisor (dvs_q),
        .p_out   (p_next),
        .q_bit   (q_bit)
    );

    assign q_raw = {q_q[WIDTH-2:0], q_bit};

`ifdef SIGNED_DIV_EN
    logic dvd_neg, dvs_neg, neg_q_q, neg_r_q;

    assign dvd_neg = is_signed & dividend[WIDTH-1];
    assign dvs_neg = is_signed & divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? -dividend : dividend;
    assign dvs_mag = dvs_neg ? -divisor : divisor;
    // Quotient negative on sign mismatch; remainder follows the dividend.
    assign q_res   = neg_q_q ? -q_raw : q_raw;
    assign r_res   = neg_r_q ? -p_next : p_next;
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
    assign q_res   = q_raw;
    assign r_res   = p_next;
`endif

    // NOTE: registers update with <= so each one samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no branch can infer a latch.
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: state_d = IDLE;
            RUN: begin
                busy = 1'b1;
                if (cnt_q == LAST_CNT) begin
                    last    = 1'b1;
                    state_d = FIN;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // FIN accepts a new request so back-to-back issue has no idle gap.
        if (start && (state_q == IDLE || state_q == FIN)) begin
            accept  = 1'b1;
            state_d = (divisor == '0) ? FIN : RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            p_q         <= '0;
            q_q         <= '0;
            dvs_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
`endif
        end else if (accept) begin
            cnt_q       <= '0;
            p_q         <= '0;
            q_q         <= dvd_mag;
            dvs_q       <= dvs_mag;
            div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_q_q     <= dvd_neg ^ dvs_neg;
            neg_r_q     <= dvd_neg;
`endif
            if (divisor == '0) begin
                quotient    <= DBZ_Q;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state_q == RUN) begin
            cnt_q <= cnt_q + CNT_W'(1);
            p_q   <= p_next;
            q_q   <= q_raw;
            if (last) begin
                quotient  <= q_res;
                remainder <= r_res;
            end
        end
    end

endmodule

// File: tb/tb_iterative_divider.sv
// Self-checking bench for iterative_divider: vector table plus handshake corner sequences.
module tb_iterative_divider;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
        int           start_cyc;
        string        tag;
    } exp_t;

    typedef struct {
        logic [W-1:0] dvd;
        logic [W-1:0] dvs;
        logic         sgn;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
`ifdef SIGNED_DIV_EN
    logic         is_signed;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;
    int   done_cnt = 0;
    exp_t sb[$];
    vec_t vecs[$];

    iterative_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef SIGNED_DIV_EN
        .is_signed   (is_signed),
`endif
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
    endtask

    // Scoreboard: every done pulse pops the oldest expected result.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            check("busy_low_at_done", busy, 0);
            if (sb.size() == 0) begin
                check("spurious_done", done, 0);
            end else begin
                e = sb.pop_front();
                check({e.tag, " quotient"}, quotient, e.q);
                check({e.tag, " remainder"}, remainder, e.r);
                check({e.tag, " div_by_zero"}, div_by_zero, e.dbz);
                check({e.tag, " latency"}, cyc - e.start_cyc, e.lat);
            end
        end
    end

    // Called #1 after an edge; start is accepted at the following edge if the DUT is free.
    task automatic drive_start(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input logic sgn,
                               input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz,
                               input string tag);
        exp_t e;
        dividend = dvd;
        divisor  = dvs;
        start    = 1'b1;
`ifdef SIGNED_DIV_EN
        is_signed = sgn;
`endif
        e.q         = q;
        e.r         = r;
        e.dbz       = dbz;
        e.lat       = (dvs == 0) ? 1 : W + 1;
        e.start_cyc = cyc;
        e.tag       = sgn ? {tag, " signed"} : tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic issue(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input logic sgn,
                         input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz,
                         input string tag);
        @(posedge clk);
        #1;
        drive_start(dvd, dvs, sgn, q, r, dbz, tag);
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (sb.size() != 0 && i < budget) begin
            @(posedge clk);
            #2;
            i++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic found;
        int   dc;

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
`ifdef SIGNED_DIV_EN
        is_signed = 1'b0;
`endif

        vecs.push_back('{32'hFFFF_FFFF, 32'd1,          1'b0, 32'hFFFF_FFFF, 32'd0,       1'b0});
        vecs.push_back('{32'd5,         32'd9,          1'b0, 32'd0,         32'd5,       1'b0});
        vecs.push_back('{32'd1234,      32'd0,          1'b0, 32'hFFFF_FFFF, 32'd1234,    1'b1});
        vecs.push_back('{32'd10,        32'd3,          1'b0, 32'd3,         32'd1,       1'b0});
        vecs.push_back('{32'd7,         32'd7,          1'b0, 32'd1,         32'd0,       1'b0});
        vecs.push_back('{32'd0,         32'd5,          1'b0, 32'd0,         32'd0,       1'b0});
        vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF,  1'b0, 32'd1,         32'd0,       1'b0});
        vecs.push_back('{32'd1,         32'hFFFF_FFFF,  1'b0, 32'd0,         32'd1,       1'b0});
        vecs.push_back('{32'h8000_0000, 32'd2,          1'b0, 32'h4000_0000, 32'd0,       1'b0});
        vecs.push_back('{32'd0,         32'd0,          1'b0, 32'hFFFF_FFFF, 32'd0,       1'b1});
        vecs.push_back('{32'hDEAD_BEEF, 32'h0000_1234,  1'b0, 32'd801701,    32'd1899,    1'b0});
`ifdef SIGNED_DIV_EN
        vecs.push_back('{32'hFFFF_FFF9, 32'd2,          1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF,  1'b1, 32'h8000_0000, 32'd0,       1'b0});
        vecs.push_back('{32'hFFFF_FFF9, 32'd2,          1'b0, 32'h7FFF_FFFC, 32'd1,       1'b0});
        vecs.push_back('{32'hFFFF_FFFB, 32'd0,          1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1});
        vecs.push_back('{32'd7,         32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD, 32'd1,       1'b0});
`endif

        repeat (2) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset quotient", quotient, 0);
        check("reset remainder", remainder, 0);
        check("reset div_by_zero", div_by_zero, 0);
        reset = 1'b0;

        busy_cnt = 0;
        issue(100, 7, 1'b0, 14, 2, 1'b0, "100/7");
        wait_done(100);
        check("100/7 busy_cycles", busy_cnt, 32);

        foreach (vecs[i]) begin
            issue(vecs[i].dvd, vecs[i].dvs, vecs[i].sgn, vecs[i].q, vecs[i].r, vecs[i].dbz,
                  $sformatf("vec%0d", i));
            wait_done(100);
        end

        // A start pulse mid-RUN must be ignored; a start during FIN must be taken.
        issue(50, 5, 1'b0, 10, 0, 1'b0, "50/5");
        repeat (10) @(posedge clk);
        #1;
        dividend = 99;
        divisor  = 4;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ignored start keeps busy", busy, 1);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #1;
            found = done;
        end
        if (!found) begin
            check("fin_timeout", found, 1);
        end else begin
            drive_start(99, 4, 1'b0, 24, 3, 1'b0, "99/4 b2b");
            check("b2b no idle gap", busy, 1);
        end
        wait_done(100);

        // Reset in the middle of 1000/3 abandons it silently.
        @(posedge clk);
        #1;
        dividend = 1000;
        divisor  = 3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("pre-reset busy", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrun reset busy", busy, 0);
        check("midrun reset done", done, 0);
        check("midrun reset quotient", quotient, 0);
        check("midrun reset remainder", remainder, 0);
        check("midrun reset div_by_zero", div_by_zero, 0);
        dc = done_cnt;
        repeat (40) @(posedge clk);
        #1;
        check("no done after reset", done_cnt - dc, 0);
        issue(1000, 3, 1'b0, 333, 1, 1'b0, "1000/3 fresh");
        wait_done(100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
